// File: rtl/vga_hmst_pkg.sv
// Shared types and constants for the VGA host-port initiator.
package vga_hmst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Byte enables parked when no cycle is driven.
  localparam logic [3:0]  BE_IDLE   = 4'hF;
  // Read data returned for an aborted cycle.
  localparam logic [31:0] TMO_RDATA = 32'hFFFF_FFFF;

  // IO space only decodes the low 16 address bits.
  function automatic logic [22:0] map_addr(input logic mem_io_n, input logic [22:0] addr);
    return mem_io_n ? addr : {7'd0, addr[15:0]};
  endfunction

endpackage

// File: rtl/vga_hmst_if.sv
// Request/response channel plus the VGA core host-port bus.
interface vga_hmst_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mem_io_n;
  logic        cmd_rd_wr_n;
  logic [22:0] cmd_addr;
  logic [3:0]  cmd_be_n;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [22:0] t_haddr;
  logic [3:0]  t_byte_en_n;
  logic        t_mem_io_n;
  logic        t_hrd_hwr_n;
  logic        t_svga_sel;
  logic [31:0] t_hdata_in;
  logic [31:0] t_hdata_out;
  logic        h_t_ready_n;

  modport master (
    input  cmd_valid, cmd_mem_io_n, cmd_rd_wr_n, cmd_addr, cmd_be_n, cmd_wdata,
           rsp_ready, t_hdata_out, h_t_ready_n,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           t_haddr, t_byte_en_n, t_mem_io_n, t_hrd_hwr_n, t_svga_sel, t_hdata_in
  );

  modport slave (
    output cmd_valid, cmd_mem_io_n, cmd_rd_wr_n, cmd_addr, cmd_be_n, cmd_wdata,
           rsp_ready, t_hdata_out, h_t_ready_n,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           t_haddr, t_byte_en_n, t_mem_io_n, t_hrd_hwr_n, t_svga_sel, t_hdata_in
  );
endinterface

// File: rtl/vga_hmst_tmo_cnt.sv
// WAIT-state watchdog: counts WAIT cycles and flags the last allowed one.
module vga_hmst_tmo_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Cleared while the cycle is set up, then counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)    cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= cnt_q + W'(1);
  end

  // The count reaches TIMEOUT_CYCLES on the edge that this flag is acted upon.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/vga_host_master.sv
// Host-side initiator for the VGA core host port: one command at a time,
// IDLE -> SETUP -> WAIT -> RESP. Define VGA_HMST_TIMEOUT_EN to abort WAIT
// after TIMEOUT_CYCLES cycles; otherwise WAIT is unbounded.
module vga_host_master
  import vga_hmst_pkg::*;
#(
  parameter int unsigned IDLE_GAP       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        h_hclk,
  input  logic        h_reset_n,
  vga_hmst_if.master  bus
);
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP);

  state_t     state_q, state_d;
  logic [3:0] gap_q;
  logic       accept;
  logic       core_done;
  logic       tmo_hit;

  assign bus.cmd_ready = h_reset_n && (state_q == ST_IDLE) && (gap_q == 4'd0);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign core_done     = !bus.h_t_ready_n;

`ifdef VGA_HMST_TIMEOUT_EN
  vga_hmst_tmo_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo_cnt (
    .clk     (h_hclk),
    .rst_n   (h_reset_n),
    .clr     (state_q == ST_SETUP),
    .en      (state_q == ST_WAIT),
    .expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge h_hclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!h_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode; ready outranks a simultaneous timeout.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)                state_d = ST_SETUP;
      ST_SETUP:                            state_d = ST_WAIT;
      ST_WAIT:  if (core_done || tmo_hit)  state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready)         state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Registered bus, response and inter-cycle gap.
  always_ff @(posedge h_hclk) begin
    if (!h_reset_n) begin
      gap_q           <= 4'd0;
      bus.t_haddr     <= '0;
      bus.t_byte_en_n <= BE_IDLE;
      bus.t_mem_io_n  <= 1'b1;
      bus.t_hrd_hwr_n <= 1'b1;
      bus.t_svga_sel  <= 1'b0;
      bus.t_hdata_in  <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gap_q != 4'd0) gap_q <= gap_q - 4'd1;
          if (accept) begin
            bus.t_haddr     <= map_addr(bus.cmd_mem_io_n, bus.cmd_addr);
            bus.t_byte_en_n <= bus.cmd_be_n;
            bus.t_mem_io_n  <= bus.cmd_mem_io_n;
            bus.t_hrd_hwr_n <= bus.cmd_rd_wr_n;
            bus.t_hdata_in  <= bus.cmd_wdata;
          end
        end
        ST_SETUP: bus.t_svga_sel <= 1'b1;
        ST_WAIT: begin
          if (core_done || tmo_hit) begin
            bus.rsp_valid   <= 1'b1;
            bus.t_svga_sel  <= 1'b0;
            bus.t_byte_en_n <= BE_IDLE;
          end
          if (core_done) begin
            bus.rsp_rdata   <= bus.t_hrd_hwr_n ? bus.t_hdata_out : 32'd0;
            bus.rsp_timeout <= 1'b0;
          end else if (tmo_hit) begin
            bus.rsp_rdata   <= TMO_RDATA;
            bus.rsp_timeout <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            gap_q         <= GAP_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_host_master.sv
// Directed bench for vga_host_master (IDLE_GAP=1, TIMEOUT_CYCLES=8).
// Honours VGA_HMST_TIMEOUT_EN for the timeout scenario.
module tb_vga_host_master;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  vga_hmst_if bus ();

  vga_host_master #(.IDLE_GAP(1), .TIMEOUT_CYCLES(8)) dut (
    .h_hclk    (clk),
    .h_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_cmd_ready"},   32'(bus.cmd_ready),   32'd0);
    check({pfx, "_t_haddr"},     32'(bus.t_haddr),     32'd0);
    check({pfx, "_t_byte_en_n"}, 32'(bus.t_byte_en_n), 32'hF);
    check({pfx, "_t_mem_io_n"},  32'(bus.t_mem_io_n),  32'd1);
    check({pfx, "_t_hrd_hwr_n"}, 32'(bus.t_hrd_hwr_n), 32'd1);
    check({pfx, "_t_svga_sel"},  32'(bus.t_svga_sel),  32'd0);
    check({pfx, "_t_hdata_in"},  bus.t_hdata_in,       32'd0);
    check({pfx, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    check({pfx, "_rsp_rdata"},   bus.rsp_rdata,        32'd0);
    check({pfx, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
  endtask

  // Present a command and return just after the edge that accepts it.
  task automatic issue(input logic mem_io_n, input logic rd_wr_n, input logic [22:0] addr,
                       input logic [3:0] be_n, input logic [31:0] wdata);
    int n;
    bus.cmd_mem_io_n = mem_io_n;
    bus.cmd_rd_wr_n  = rd_wr_n;
    bus.cmd_addr     = addr;
    bus.cmd_be_n     = be_n;
    bus.cmd_wdata    = wdata;
    bus.cmd_valid    = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
    check("issue_cmd_ready_bound", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // From the first WAIT cycle: pulse ready in WAIT cycle ready_on, count strobe cycles.
  task automatic wait_ready(input int ready_on, output int hi_cnt);
    hi_cnt = 0;
    for (int k = 1; k <= ready_on; k++) begin
      if (bus.t_svga_sel) hi_cnt++;
      if (k == ready_on) bus.h_t_ready_n = 1'b0;
      step();
    end
    bus.h_t_ready_n = 1'b1;
  endtask

  task automatic rsp_handshake();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int   hi;
    int   first_hi;
    int   second_hi;
    logic sel_hist [24];
    logic saw_rsp;
    logic done;

    rst_n            = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_mem_io_n = 1'b1;
    bus.cmd_rd_wr_n  = 1'b1;
    bus.cmd_addr     = '0;
    bus.cmd_be_n     = 4'hF;
    bus.cmd_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    bus.t_hdata_out  = '0;
    bus.h_t_ready_n  = 1'b1;

    // Reset state.
    step();
    step();
    check_reset_values("rst");
    rst_n = 1'b1;
    #1;
    check("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 1: IO write, ready in the third WAIT cycle.
    issue(1'b0, 1'b0, 23'h0003C4, 4'b1100, 32'h0000_0102);
    check("t1_setup_haddr",   32'(bus.t_haddr),     32'h3C4);
    check("t1_setup_be_n",    32'(bus.t_byte_en_n), 32'hC);
    check("t1_setup_mem_io",  32'(bus.t_mem_io_n),  32'd0);
    check("t1_setup_rd_wr",   32'(bus.t_hrd_hwr_n), 32'd0);
    check("t1_setup_wdata",   bus.t_hdata_in,       32'h0000_0102);
    check("t1_setup_sel",     32'(bus.t_svga_sel),  32'd0);
    check("t1_setup_cmd_rdy", 32'(bus.cmd_ready),   32'd0);
    step();
    check("t1_wait_sel", 32'(bus.t_svga_sel), 32'd1);
    wait_ready(3, hi);
    check("t1_sel_hi_cycles", 32'(hi),                 32'd3);
    check("t1_rsp_valid",     32'(bus.rsp_valid),      32'd1);
    check("t1_rsp_rdata",     bus.rsp_rdata,           32'd0);
    check("t1_rsp_timeout",   32'(bus.rsp_timeout),    32'd0);
    check("t1_resp_sel",      32'(bus.t_svga_sel),     32'd0);
    check("t1_resp_be_n",     32'(bus.t_byte_en_n),    32'hF);
    check("t1_resp_haddr",    32'(bus.t_haddr),        32'h3C4);
    rsp_handshake();
    check("t1_post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t1_gap_cmd_ready",  32'(bus.cmd_ready), 32'd0);
    step();
    check("t1_gap_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 2: memory read, ready in the fifth WAIT cycle.
    issue(1'b1, 1'b1, 23'h0A0000, 4'h0, 32'h0);
    check("t2_setup_haddr",  32'(bus.t_haddr),     32'h0A0000);
    check("t2_setup_mem_io", 32'(bus.t_mem_io_n),  32'd1);
    check("t2_setup_rd_wr",  32'(bus.t_hrd_hwr_n), 32'd1);
    bus.t_hdata_out = 32'hDEAD_BEEF;
    step();
    wait_ready(5, hi);
    check("t2_sel_hi_cycles", 32'(hi),              32'd5);
    check("t2_rsp_valid",     32'(bus.rsp_valid),   32'd1);
    check("t2_rsp_rdata",     bus.rsp_rdata,        32'hDEAD_BEEF);
    check("t2_rsp_timeout",   32'(bus.rsp_timeout), 32'd0);
    rsp_handshake();
    step();

    // 3: back-to-back IO writes (upper address bits must be dropped), ready
    // held low so every WAIT ends immediately. Strobe-to-strobe the select is
    // low for RESP, the IDLE_GAP cycle, the accept cycle and SETUP.
    bus.cmd_mem_io_n = 1'b0;
    bus.cmd_rd_wr_n  = 1'b0;
    bus.cmd_addr     = 23'h1203C4;
    bus.cmd_be_n     = 4'h0;
    bus.cmd_wdata    = 32'h5A5A_0001;
    bus.cmd_valid    = 1'b1;
    bus.rsp_ready    = 1'b1;
    bus.h_t_ready_n  = 1'b0;
    step();
    check("t3_io_addr_masked", 32'(bus.t_haddr), 32'h0003C4);
    for (int i = 0; i < 24; i++) begin
      sel_hist[i] = bus.t_svga_sel;
      step();
    end
    bus.cmd_valid = 1'b0;
    repeat (8) step();
    bus.h_t_ready_n = 1'b1;
    bus.rsp_ready   = 1'b0;
    step();
    first_hi  = -1;
    second_hi = -1;
    for (int i = 1; i < 24; i++) begin
      if (sel_hist[i] && !sel_hist[i-1]) begin
        if (first_hi < 0)       first_hi  = i;
        else if (second_hi < 0) second_hi = i;
      end
    end
    check("t3_two_strobes_seen", 32'(second_hi > first_hi && first_hi >= 0), 32'd1);
    check("t3_strobe_width",     32'(sel_hist[first_hi + 1]),                32'd0);
    check("t3_sel_low_between",  32'(second_hi - first_hi - 1),              32'd4);
    check("t3_drained_idle",     32'(bus.cmd_ready),                          32'd1);
    check("t3_drained_no_rsp",   32'(bus.rsp_valid),                          32'd0);

    // 4: no ready from the core.
    issue(1'b1, 1'b1, 23'h000010, 4'h0, 32'h0);
    step();
`ifdef VGA_HMST_TIMEOUT_EN
    hi   = 0;
    done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.rsp_valid) begin
        done = 1'b1;
        break;
      end
      if (bus.t_svga_sel) hi++;
      step();
    end
    check("t4_tmo_bound",       32'(done),            32'd1);
    check("t4_tmo_wait_cycles", 32'(hi),              32'd8);
    check("t4_tmo_flag",        32'(bus.rsp_timeout), 32'd1);
    check("t4_tmo_rdata",       bus.rsp_rdata,        32'hFFFF_FFFF);
    check("t4_tmo_sel",         32'(bus.t_svga_sel),  32'd0);
    rsp_handshake();
    step();
`else
    repeat (1000) step();
    check("t4_still_wait_sel",  32'(bus.t_svga_sel), 32'd1);
    check("t4_still_wait_rsp",  32'(bus.rsp_valid),  32'd0);
    bus.t_hdata_out = 32'h0BAD_F00D;
    wait_ready(1, hi);
    check("t4_late_rsp_valid",  32'(bus.rsp_valid),   32'd1);
    check("t4_late_rdata",      bus.rsp_rdata,        32'h0BAD_F00D);
    check("t4_late_no_tmo",     32'(bus.rsp_timeout), 32'd0);
    rsp_handshake();
    step();
`endif

    // 5: reset asserted while in WAIT drops the command.
    issue(1'b1, 1'b0, 23'h055555, 4'h3, 32'hCAFE_0005);
    step();
    step();
    rst_n = 1'b0;
    step();
    check_reset_values("t5");
    rst_n = 1'b1;
    bus.h_t_ready_n = 1'b0;
    saw_rsp = 1'b0;
    repeat (5) begin
      step();
      if (bus.rsp_valid || bus.t_svga_sel) saw_rsp = 1'b1;
    end
    bus.h_t_ready_n = 1'b1;
    check("t5_no_rsp_after_reset", 32'(saw_rsp),       32'd0);
    check("t5_idle_cmd_ready",     32'(bus.cmd_ready), 32'd1);

    // 6: response held under back-pressure; stray ready and new data ignored.
    bus.t_hdata_out = 32'h1234_5678;
    issue(1'b1, 1'b1, 23'h0A0004, 4'h0, 32'h0);
    step();
    wait_ready(1, hi);
    bus.t_hdata_out = 32'hAAAA_5555;
    bus.cmd_valid   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.h_t_ready_n = (k == 1) ? 1'b0 : 1'b1;
      step();
      check($sformatf("t6_hold%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("t6_hold%0d_rdata", k),     bus.rsp_rdata,      32'h1234_5678);
      check($sformatf("t6_hold%0d_cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
    end
    bus.h_t_ready_n = 1'b1;
    rsp_handshake();
    bus.cmd_valid = 1'b0;
    check("t6_rsp_released", 32'(bus.rsp_valid), 32'd0);
    repeat (3) step();
    check("t6_no_stray_cycle", 32'(bus.t_svga_sel), 32'd0);
    check("t6_final_idle",     32'(bus.cmd_ready),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
